// File: rtl/ls595_sipo_if.sv
// Pin bundle of the ls595_sipo shift/storage register: chip-level inputs and
// the parallel/cascade/framing outputs.
interface ls595_sipo_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             srclk;
  logic             ser;
  logic             n_srclr;
  logic             rclk;
  logic             n_oe;
  logic [WIDTH-1:0] q;
  logic             qh_prime;
  logic [CntW-1:0]  bit_cnt;
  logic             frame_ok;
  logic             overrun;

  modport master (
    output srclk, ser, n_srclr, rclk, n_oe,
    input  q, qh_prime, bit_cnt, frame_ok, overrun
  );

  modport slave (
    input  srclk, ser, n_srclr, rclk, n_oe,
    output q, qh_prime, bit_cnt, frame_ok, overrun
  );
endinterface

// File: rtl/ls595_sipo.sv
// 74LS595-style serial-in/parallel-out register with storage latch and framing
// status; chip clocks are sampled levels edge-detected on the system clock.
module ls595_sipo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  ls595_sipo_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             frame_ok_q, frame_ok_d;
  logic             overrun_q, overrun_d;
  logic             srclk_q, rclk_q;
  logic             sh_edge, lt_edge, shift_acc;

  assign sh_edge   = bus.srclk & ~srclk_q;
  assign lt_edge   = bus.rclk & ~rclk_q;
  assign shift_acc = sh_edge & bus.n_srclr;

  // Edge detectors reset high so a level already high at release is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q       <= '0;
      store_q    <= '0;
      cnt_q      <= '0;
      frame_ok_q <= 1'b0;
      overrun_q  <= 1'b0;
      srclk_q    <= 1'b1;
      rclk_q     <= 1'b1;
    end else begin
      sr_q       <= sr_d;
      store_q    <= store_d;
      cnt_q      <= cnt_d;
      frame_ok_q <= frame_ok_d;
      overrun_q  <= overrun_d;
      srclk_q    <= bus.srclk;
      rclk_q     <= bus.rclk;
    end
  end

  always_comb begin
    sr_d       = sr_q;
    store_d    = store_q;
    cnt_d      = cnt_q;
    frame_ok_d = frame_ok_q;
    overrun_d  = overrun_q;

    if (!bus.n_srclr) begin
      sr_d = '0;
    end else if (sh_edge) begin
      sr_d = {sr_q[WIDTH-2:0], bus.ser};
    end

    // Latch captures the pre-shift/pre-clear value, one stage behind on a tie.
    if (lt_edge) begin
      store_d    = sr_q;
      frame_ok_d = (cnt_q == CntFull);
      overrun_d  = 1'b0;
    end else if (shift_acc && (cnt_q == CntFull)) begin
      overrun_d = 1'b1;
    end

    if (!bus.n_srclr) begin
      cnt_d = '0;
    end else if (lt_edge) begin
      cnt_d = shift_acc ? CntW'(1) : '0;
    end else if (shift_acc && (cnt_q != CntFull)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_comb begin
    bus.q        = bus.n_oe ? '0 : store_q;
    bus.qh_prime = sr_q[WIDTH-1];
    bus.bit_cnt  = cnt_q;
    bus.frame_ok = frame_ok_q;
    bus.overrun  = overrun_q;
  end
endmodule
